// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues handshaked imem requests and holds each
// fetched word for decode, applying redirects at any point including mid-request.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ack,
  output logic [31:0] pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StReq, StIssue} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] count_q, count_d;
  logic        squash_q, squash_d;

  logic [31:0] target;
  logic [31:0] flow_pc;
  logic        unused_target_lsbs;

  assign target             = {redirect_target[31:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];
  // PC after honouring a same-cycle redirect
  assign flow_pc            = redirect ? target : pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    count_d    = count_q;
    squash_d   = squash_q;

    unique case (state_q)
      StIdle: begin
        pc_d = flow_pc;
        if (!stall) begin
          state_d    = StReq;
          req_addr_d = flow_pc;
        end
      end

      StReq: begin
        if (imem_ready) begin
          if (squash_q || redirect) begin
            // Completed request belongs to a stale path: drop the word
            squash_d   = 1'b0;
            pc_d       = flow_pc;
            req_addr_d = flow_pc;
            state_d    = stall ? StIdle : StReq;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = req_addr_q;
            state_d   = StIssue;
          end
        end else if (redirect) begin
          // Memory cannot abandon the access; let it finish and discard it
          squash_d = 1'b1;
          pc_d     = target;
        end
      end

      StIssue: begin
        if (inst_ack) begin
          count_d    = count_q + 32'd1;
          pc_d       = redirect ? target : pc_q + 32'd4;
          req_addr_d = pc_d;
          state_d    = stall ? StIdle : StReq;
        end else if (redirect) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = stall ? StIdle : StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
      count_q    <= 32'd0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      count_q    <= count_d;
      squash_q   <= squash_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = (state_q == StReq) ? req_addr_q : pc_q;
  assign inst_valid  = (state_q == StIssue);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign pc          = pc_q;
  assign fetch_count = count_q;

endmodule
